// File: rtl/timer_control_unit_pkg.sv
// Shared definitions for the countdown control stage and the digit-chain top level.
// Holds the state encodings and the default tick rate.
package timer_control_unit_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'b00;
    localparam logic [1:0] STATE_RUN   = 2'b01;
    localparam logic [1:0] STATE_PAUSE = 2'b10;
    localparam logic [1:0] STATE_DONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = STATE_IDLE,
        ST_RUN   = STATE_RUN,
        ST_PAUSE = STATE_PAUSE,
        ST_DONE  = STATE_DONE
    } state_t;

    // One tick per second at 100 MHz; the prescaler width must cover TICK_DIV.
    localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;
    localparam int unsigned DEFAULT_CNT_W    = 27;

endpackage

// File: rtl/timer_control_unit_tick_prescaler.sv
// Modulo-TICK_DIV cycle counter. terminal is high while the count sits on its last
// value; the owner gates it with its own enable to form a one-cycle tick.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            if (count_reg == LAST_COUNT) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    // Ungated so the owner's next-state logic has no loop back through enable.
    assign terminal = (count_reg == LAST_COUNT);

endmodule

// File: rtl/timer_control_unit.sv
// Run/pause/done controller that turns the start/stop button and a prescaled clock
// into decrease_timer pulses for the least-significant digit of the countdown chain.
module timer_control_unit
    import timer_control_unit_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop_button,
    input  logic       set_time_button,
    input  logic       timer_at_zero,
    output logic       decrease_timer,
    output logic       running,
    output logic       time_up,
    output logic       alarm_led,
    output logic [1:0] state
);

    state_t state_reg, state_next;
    logic   btn_prev_reg;
    logic   decrease_reg, decrease_next;
    logic   running_reg, running_next;
    logic   time_up_reg, time_up_next;
    logic   alarm_reg, alarm_next;
    logic   presc_enable, presc_clear, presc_terminal;
    logic   start_edge;

    assign start_edge = start_stop_button & ~btn_prev_reg;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_prescaler (
        .clock    (clock),
        .reset    (reset),
        .enable   (presc_enable),
        .clear    (presc_clear),
        .terminal (presc_terminal)
    );

    // History resets high so a button held through reset is not taken as a press.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            btn_prev_reg <= 1'b1;
            decrease_reg <= 1'b0;
            running_reg  <= 1'b0;
            time_up_reg  <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            btn_prev_reg <= start_stop_button;
            decrease_reg <= decrease_next;
            running_reg  <= running_next;
            time_up_reg  <= time_up_next;
            alarm_reg    <= alarm_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        decrease_next = 1'b0;
        alarm_next    = alarm_reg;
        presc_enable  = 1'b0;
        presc_clear   = 1'b0;

        if (set_time_button) begin
            state_next  = ST_IDLE;
            presc_clear = 1'b1;
            alarm_next  = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    presc_clear = 1'b1;
                    alarm_next  = 1'b0;
                    if (start_edge && !timer_at_zero) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (timer_at_zero) begin
                        state_next  = ST_DONE;
                        presc_clear = 1'b1;
                    end else if (start_edge) begin
                        state_next = ST_PAUSE;
                    end else begin
                        presc_enable  = 1'b1;
                        decrease_next = presc_terminal;
                    end
                end
                ST_PAUSE: begin
                    // Count is frozen here so a resume finishes the partial tick.
                    if (timer_at_zero) begin
                        state_next  = ST_DONE;
                        presc_clear = 1'b1;
                    end else if (start_edge) begin
                        state_next = ST_RUN;
                    end
                end
                ST_DONE: begin
                    // The chain stays at zero throughout DONE, so timer_at_zero is moot here.
                    if (start_edge) begin
                        state_next  = ST_IDLE;
                        presc_clear = 1'b1;
                        alarm_next  = 1'b0;
                    end else begin
                        presc_enable = 1'b1;
                        if (presc_terminal) begin
                            alarm_next = ~alarm_reg;
                        end
                    end
                end
                default: begin
                    state_next  = ST_IDLE;
                    presc_clear = 1'b1;
                    alarm_next  = 1'b0;
                end
            endcase
        end

        running_next = (state_next == ST_RUN);
        time_up_next = (state_next == ST_DONE);
    end

    assign decrease_timer = decrease_reg;
    assign running        = running_reg;
    assign time_up        = time_up_reg;
    assign alarm_led      = alarm_reg;
    assign state          = state_reg;

endmodule

// File: tb/tb_timer_control_unit.sv
// Directed bench for timer_control_unit with TICK_DIV=4: a per-cycle reference model
// plus hand-computed expectations at the key points of each scenario.
module tb_timer_control_unit;

    localparam int TICK = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_stop_button;
    logic       set_time_button;
    logic       timer_at_zero;
    logic       decrease_timer;
    logic       running;
    logic       time_up;
    logic       alarm_led;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause, 3 done; elapsed = cycles into the current tick.
    int m_mode    = 0;
    int m_elapsed = 0;
    int m_prev    = 1;
    int m_pulse   = 0;
    int m_alarm   = 0;

    timer_control_unit #(
        .TICK_DIV (TICK),
        .CNT_W    (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start_stop_button (start_stop_button),
        .set_time_button   (set_time_button),
        .timer_at_zero     (timer_at_zero),
        .decrease_timer    (decrease_timer),
        .running           (running),
        .time_up           (time_up),
        .alarm_led         (alarm_led),
        .state             (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press();
        start_stop_button = 1'b1;
        step(1);
        start_stop_button = 1'b0;
    endtask

    // Model update and full output comparison on every clock edge.
    initial begin
        int edge_seen;
        forever begin
            @(posedge clock);
            if (!reset) begin
                m_mode = 0; m_elapsed = 0; m_prev = 1; m_pulse = 0; m_alarm = 0;
            end else begin
                edge_seen = (start_stop_button && !m_prev) ? 1 : 0;
                m_prev    = start_stop_button ? 1 : 0;
                m_pulse   = 0;
                if (set_time_button) begin
                    m_mode = 0; m_elapsed = 0; m_alarm = 0;
                end else if (m_mode == 0) begin
                    if (edge_seen == 1 && !timer_at_zero) begin m_mode = 1; m_elapsed = 0; end
                end else if (m_mode == 1) begin
                    if (timer_at_zero) begin m_mode = 3; m_elapsed = 0; end
                    else if (edge_seen == 1) m_mode = 2;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == TICK) begin m_elapsed = 0; m_pulse = 1; end
                    end
                end else if (m_mode == 2) begin
                    if (timer_at_zero) begin m_mode = 3; m_elapsed = 0; end
                    else if (edge_seen == 1) m_mode = 1;
                end else begin
                    if (edge_seen == 1) begin m_mode = 0; m_elapsed = 0; m_alarm = 0; end
                    else begin
                        m_elapsed++;
                        if (m_elapsed == TICK) begin m_elapsed = 0; m_alarm = 1 - m_alarm; end
                    end
                end
            end
            #1;
            chk("model_state", state, m_mode);
            chk("model_running", running, (m_mode == 1) ? 1 : 0);
            chk("model_time_up", time_up, (m_mode == 3) ? 1 : 0);
            chk("model_decrease", decrease_timer, m_pulse);
            chk("model_alarm", alarm_led, m_alarm);
        end
    end

    initial begin
        reset = 1'b0; start_stop_button = 1'b1; set_time_button = 1'b0; timer_at_zero = 1'b0;
        step(3);
        // Release reset with the button still held: no press must be seen.
        reset = 1'b1;
        step(3);
        chk("reset_state", state, 0);
        chk("reset_running", running, 0);
        chk("reset_decrease", decrease_timer, 0);
        chk("reset_time_up", time_up, 0);
        chk("reset_alarm", alarm_led, 0);
        start_stop_button = 1'b0;
        step(1);

        // Start while already at zero: stays idle.
        timer_at_zero = 1'b1;
        press();
        chk("idle_zero_start", state, 0);
        timer_at_zero = 1'b0;
        step(1);

        // Run: pulses 4, 8 and 12 cycles after entry, one cycle wide.
        press();
        chk("run_entry_state", state, 1);
        chk("run_entry_running", running, 1);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("run_pulse_k%0d", k), decrease_timer, (k % 4 == 0) ? 1 : 0);
        end

        // Pause two cycles into a tick, hold ten cycles, resume: pulse two cycles later.
        step(2);
        press();
        chk("pause_state", state, 2);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("pause_hold_state", state, 2);
            chk("pause_no_pulse", decrease_timer, 0);
        end
        press();
        chk("resume_state", state, 1);
        step(1);
        chk("resume_pulse_early", decrease_timer, 0);
        step(1);
        chk("resume_pulse", decrease_timer, 1);

        // Zero reported on a terminal-count cycle: no pulse, go to DONE.
        step(3);
        timer_at_zero = 1'b1;
        step(1);
        chk("done_state", state, 3);
        chk("done_time_up", time_up, 1);
        chk("done_no_pulse", decrease_timer, 0);
        chk("done_running", running, 0);
        step(3);
        chk("alarm_before_toggle", alarm_led, 0);
        step(1);
        chk("alarm_first_toggle", alarm_led, 1);
        step(4);
        chk("alarm_second_toggle", alarm_led, 0);
        step(4);
        chk("alarm_third_toggle", alarm_led, 1);

        // set_time and start together from DONE: set_time wins, alarm cleared.
        set_time_button = 1'b1;
        press();
        chk("settime_state", state, 0);
        chk("settime_time_up", time_up, 0);
        chk("settime_alarm", alarm_led, 0);
        // Holding set_time keeps the unit idle even with a press.
        step(1);
        press();
        chk("settime_held_state", state, 0);
        set_time_button = 1'b0;
        timer_at_zero = 1'b0;
        step(1);

        // Reset mid-tick during RUN, then a fresh start gets a full tick.
        press();
        step(2);
        reset = 1'b0;
        step(1);
        chk("midreset_state", state, 0);
        chk("midreset_running", running, 0);
        chk("midreset_decrease", decrease_timer, 0);
        reset = 1'b1;
        step(1);
        press();
        chk("restart_state", state, 1);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("restart_pulse_k%0d", k), decrease_timer, (k == 4) ? 1 : 0);
        end

        // DONE left by a start press alone.
        timer_at_zero = 1'b1;
        step(1);
        chk("done2_state", state, 3);
        timer_at_zero = 1'b0;
        press();
        chk("done_exit_state", state, 0);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_control_unit.md
Name: timer_control_unit

Overview:
- Upstream control stage for the digit_timer chain. Converts the user start/stop button and a free-running clock into one-cycle decrease_timer pulses at a fixed tick rate.
- Runs a run/pause/done state machine and stops the countdown when the digit chain reports all-zero.
- Drives decrease_timer of the least-significant digit_timer and the alarm/status outputs.

Parameters:
- TICK_DIV, 100000000, clock cycles per countdown tick (1 s at 100 MHz); bench uses 4.
- CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start_stop_button  in  1  debounced level; rising edge toggles run/pause
- set_time_button  in  1  same signal fed to digit chain; returns unit to IDLE
- timer_at_zero  in  1  high when every digit in the chain reads 0 (cant_loan of most-significant digit)
- decrease_timer  out  1  one-cycle pulse to least-significant digit
- running  out  1  high in RUN
- time_up  out  1  high in DONE
- alarm_led  out  1  blinks in DONE
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE; prescaler=0.
  - decrease_timer=0, running=0, time_up=0, alarm_led=0.
  - Button-history register is set to 1, so a button held through reset does not count as an edge.
- Edge detect: start_edge = start_stop_button & ~btn_prev; btn_prev registered every cycle. One edge per press regardless of hold length.
- Priority in every state: set_time_button > timer_at_zero > start_edge > prescaler terminal.
- IDLE:
  - start_edge & ~timer_at_zero -> RUN, with prescaler=0.
  - start_edge & timer_at_zero -> stay IDLE.
- RUN:
  - Prescaler increments each cycle. At TICK_DIV-1 it wraps to 0 and decrease_timer=1 for exactly that cycle.
  - First pulse arrives TICK_DIV cycles after entering RUN.
  - timer_at_zero=1 -> DONE next cycle, prescaler=0, no pulse that cycle even at terminal count.
  - start_edge -> PAUSE; prescaler holds its value and no pulse is issued that cycle.
- PAUSE:
  - Prescaler frozen, decrease_timer=0.
  - start_edge -> RUN; counting resumes from the held value, so the partial tick is preserved.
- DONE:
  - time_up=1; prescaler free-runs.
  - alarm_led toggles at each terminal count.
  - decrease_timer is never asserted.
  - start_edge or set_time_button -> IDLE, with alarm_led=0 and prescaler=0.
- set_time_button=1 in any state -> IDLE next cycle, prescaler=0, decrease_timer=0 that cycle. The unit stays in IDLE while the button is held.
- Output timing:
  - decrease_timer is registered (no combinational path from inputs).
  - running, time_up and state are registered decodes of state.
- Widths:
  - Prescaler compares with TICK_DIV-1 cast to CNT_W.
  - TICK_DIV=1 is illegal; minimum is 2.

Decomposition:
- Shared package / header:
  - state encodings IDLE/RUN/PAUSE/DONE (2-bit localparams).
  - default TICK_DIV constant, shared with the digit-chain top level.
- One sub-module: tick_prescaler.
  - Inputs: clock, reset, enable, clear.
  - Output: terminal pulse.
  - Parameters: TICK_DIV, CNT_W.
- FSM, edge detect and alarm toggle stay in timer_control_unit.

Test Plan:
- Reset release with start_stop_button held at 1 -> state stays IDLE (00); all outputs 0; no spurious RUN.
- TICK_DIV=4, timer_at_zero=0, one start press -> state=01 next cycle; decrease_timer high on cycles 4, 8, 12 after entry, each exactly 1 cycle wide.
- Press start 2 cycles into a tick, wait 10 cycles, press again -> PAUSE for the whole gap, no pulses; next pulse 2 cycles after resume.
- Raise timer_at_zero in the same cycle as a terminal count -> no pulse; state=11, time_up=1; alarm_led toggles every 4 cycles.
- DONE, then set_time_button=1 and start edge in the same cycle -> state=00, time_up=0, alarm_led=0; set_time wins.
- RUN with reset=0 mid-tick for one cycle -> all outputs 0, state=00, prescaler=0; a new start gives its first pulse a full 4 cycles later.
